decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 67 ++++++
 rtl/decode_stage_instr_fields.sv | 74 +++++++
 rtl/decode_stage.sv | 104 ++++++++++
 3 files changed

// File: rtl/decode_stage_pkg.sv
// Shared decode types: opcodes, immediate/ALU types, decoded-entry record and
// the output buffer state.
package decode_stage_pkg;

  typedef logic [6:0]         opcode_t;
  typedef logic signed [31:0] imm_t;

  localparam opcode_t OP_RTYPE       = 7'b0110011;
  localparam opcode_t OP_ITYPE_LOGIC = 7'b0010011;
  localparam opcode_t OP_ITYPE_LOAD  = 7'b0000011;
  localparam opcode_t OP_ITYPE_JALR  = 7'b1100111;
  localparam opcode_t OP_STYPE       = 7'b0100011;
  localparam opcode_t OP_BTYPE       = 7'b1100011;
  localparam opcode_t OP_JTYPE       = 7'b1101111;
  localparam opcode_t OP_UTYPE_AUIPC = 7'b0010111;
  localparam opcode_t OP_UTYPE_LUI   = 7'b0110111;

  typedef enum logic [3:0] {
    ALU_OP__UNSET = 4'd0,
    ALU_ADD       = 4'd1,
    ALU_SUB       = 4'd2,
    ALU_SLL       = 4'd3,
    ALU_SLT       = 4'd4,
    ALU_SLTU      = 4'd5,
    ALU_XOR       = 4'd6,
    ALU_SRL       = 4'd7,
    ALU_SRA       = 4'd8,
    ALU_OR        = 4'd9,
    ALU_AND       = 4'd10,
    ALU_LUI       = 4'd11,
    ALU_MUL       = 4'd12,
    ALU_DIV       = 4'd13
  } alu_op_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

  typedef struct packed {
    opcode_t    opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    imm_t       imm;
    alu_op_t    alu;
    logic       illegal;
  } dec_t;

  // alt selects SUB/SRA; callers mask it where the alternate form does not exist
  function automatic alu_op_t alu_arith(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_instr_fields.sv
// Combinational instruction field, immediate, ALU-control and legality extraction.
module instr_fields
  import decode_stage_pkg::*;
#(
  parameter int ENABLE_M = 0
) (
  input  logic [31:0] i_instr,
  output dec_t        o_dec
);

  opcode_t    w_op;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_is_r, w_is_il, w_is_ld, w_is_jalr, w_is_s, w_is_b, w_is_j, w_is_auipc, w_is_lui;
  logic       w_known, w_f7_std, w_f7_m, w_illegal;

  assign w_op       = i_instr[6:0];
  assign w_f3       = i_instr[14:12];
  assign w_f7       = i_instr[31:25];
  assign w_is_r     = (w_op == OP_RTYPE);
  assign w_is_il    = (w_op == OP_ITYPE_LOGIC);
  assign w_is_ld    = (w_op == OP_ITYPE_LOAD);
  assign w_is_jalr  = (w_op == OP_ITYPE_JALR);
  assign w_is_s     = (w_op == OP_STYPE);
  assign w_is_b     = (w_op == OP_BTYPE);
  assign w_is_j     = (w_op == OP_JTYPE);
  assign w_is_auipc = (w_op == OP_UTYPE_AUIPC);
  assign w_is_lui   = (w_op == OP_UTYPE_LUI);
  assign w_known    = w_is_r | w_is_il | w_is_ld | w_is_jalr | w_is_s | w_is_b |
                      w_is_j | w_is_auipc | w_is_lui;
  assign w_f7_std   = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
  assign w_f7_m     = (ENABLE_M != 0) && (w_f7 == 7'b0000001);
  assign w_illegal  = !w_known ||
                      (w_is_r && !(w_f7_std || w_f7_m)) ||
                      (w_is_il && (w_f3[1:0] == 2'b01) && !w_f7_std);

  always_comb begin
    o_dec         = '0;
    o_dec.opcode  = w_op;
    o_dec.funct3  = (w_is_auipc || w_is_lui || w_is_j) ? 3'b000 : w_f3;
    o_dec.funct7  = (w_is_r || w_is_il) ? w_f7 : 7'b0000000;
    o_dec.illegal = w_illegal;
    // Illegal entries keep operand, immediate and ALU fields at zero
    if (!w_illegal) begin
      o_dec.rd  = (w_is_s || w_is_b) ? 5'd0 : i_instr[11:7];
      o_dec.rs1 = (w_is_auipc || w_is_lui || w_is_j) ? 5'd0 : i_instr[19:15];
      o_dec.rs2 = (w_is_r || w_is_s || w_is_b) ? i_instr[24:20] : 5'd0;
      if (w_is_il || w_is_ld || w_is_jalr)
        o_dec.imm = {{20{i_instr[31]}}, i_instr[31:20]};
      else if (w_is_s)
        o_dec.imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      else if (w_is_b)
        o_dec.imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                     i_instr[11:8], 1'b0};
      else if (w_is_j)
        o_dec.imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                     i_instr[30:21], 1'b0};
      else if (w_is_auipc || w_is_lui)
        o_dec.imm = {i_instr[31:12], 12'b0};
      if (w_is_r)
        o_dec.alu = (w_f7 == 7'b0000001) ? (w_f3[2] ? ALU_DIV : ALU_MUL)
                                         : alu_arith(w_f3, w_f7[5]);
      else if (w_is_il)
        o_dec.alu = alu_arith(w_f3, w_f7[5] && (w_f3 == 3'b101));
      else if (w_is_b)
        o_dec.alu = w_f3[2] ? (w_f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
      else if (w_is_lui)
        o_dec.alu = ALU_LUI;
      else
        o_dec.alu = ALU_ADD;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: field extraction feeding a 2-entry (output + skid)
// buffer so in_ready depends only on registered state.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [6:0]       opcode,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [XLEN-1:0]  imm_ext,
  output logic [3:0]       alu_control,
  output logic             illegal,
  output logic [CNT_W-1:0] dec_count
);

  dec_t            w_dec;
  buf_state_t      r_state, w_state_nxt;
  dec_t            r_out, r_skid;
  logic [XLEN-1:0] r_out_pc, r_skid_pc;
  logic [CNT_W-1:0] r_cnt;
  logic            w_accept, w_drain, w_load_out, w_load_skid;
  imm_t            w_imm;

  instr_fields #(.ENABLE_M(ENABLE_M)) u_fields (
    .i_instr (instr),
    .o_dec   (w_dec)
  );

  assign in_ready    = (r_state != BUF_FULL);
  assign out_valid   = (r_state != BUF_EMPTY);
  assign w_accept    = in_valid && in_ready && !flush;
  assign w_drain     = out_valid && out_ready;
  assign w_load_out  = (w_accept && ((r_state == BUF_EMPTY) || ((r_state == BUF_ONE) && w_drain))) ||
                       ((r_state == BUF_FULL) && w_drain);
  assign w_load_skid = w_accept && (r_state == BUF_ONE) && !w_drain;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BUF_EMPTY: if (w_accept) w_state_nxt = BUF_ONE;
      BUF_ONE: begin
        if (w_accept && !w_drain)      w_state_nxt = BUF_FULL;
        else if (!w_accept && w_drain) w_state_nxt = BUF_EMPTY;
      end
      BUF_FULL:  if (w_drain) w_state_nxt = BUF_ONE;
      default:   w_state_nxt = BUF_EMPTY;
    endcase
    if (flush) w_state_nxt = BUF_EMPTY;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= BUF_EMPTY;
      r_out     <= '0;
      r_skid    <= '0;
      r_out_pc  <= '0;
      r_skid_pc <= '0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_nxt;
      // From FULL the output register refills from the skid entry to keep order
      if (w_load_out) begin
        r_out    <= (r_state == BUF_FULL) ? r_skid : w_dec;
        r_out_pc <= (r_state == BUF_FULL) ? r_skid_pc : in_pc;
      end
      if (w_load_skid) begin
        r_skid    <= w_dec;
        r_skid_pc <= in_pc;
      end
      if (w_drain && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_imm       = r_out.imm;
  assign imm_ext     = XLEN'(w_imm);
  assign out_pc      = r_out_pc;
  assign opcode      = r_out.opcode;
  assign funct3      = r_out.funct3;
  assign funct7      = r_out.funct7;
  assign rd          = r_out.rd;
  assign rs1         = r_out.rs1;
  assign rs2         = r_out.rs2;
  assign alu_control = r_out.alu;
  assign illegal     = r_out.illegal;
  assign dec_count   = r_cnt;

endmodule
